// File: rtl/fetch_queue.sv
// Decoupled instruction-fetch front end: owns the fetch PC, drives the ibus and buffers {pc, instr} pairs.
// Optional same-cycle bypass of a response into an empty queue when FQ_BYPASS_EN is defined.

package fetch_queue_pkg;
  localparam int unsigned XLEN   = 64;
  localparam int unsigned INSN_W = 32;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   addr;
    logic [1:0]        size;
    logic              we;
  } ibus_req_t;

  typedef struct packed {
    logic              data_ok;
    logic [INSN_W-1:0] data;
  } ibus_resp_t;
endpackage

module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           fetch_en,
  input  logic                           redirect_valid,
  input  logic [63:0]                    redirect_pc,
  output ibus_req_t                      ireq,
  input  ibus_resp_t                     iresp,
  output logic                           deq_valid,
  input  logic                           deq_ready,
  output logic [63:0]                    deq_pc,
  output logic [31:0]                    deq_instr,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]        state_q,    state_d;
  logic [63:0]       fetch_pc_q, fetch_pc_d;
  logic [63:0]       req_pc_q,   req_pc_d;
  logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
  logic [CNT_W-1:0]  count_q,    count_d;
  logic [63:0]       pc_mem_q    [DEPTH];
  logic [63:0]       pc_mem_d    [DEPTH];
  logic [31:0]       instr_mem_q [DEPTH];
  logic [31:0]       instr_mem_d [DEPTH];

  logic              resp_ok;
  logic              bypass;
  logic              enq;
  logic              deq;
  logic [CNT_W-1:0]  count_nxt;
  logic              issue_ok;

  // Handshake qualifiers; a redirect kills both the enqueue and the dequeue of its cycle.
  always_comb begin
    resp_ok = iresp.data_ok;
`ifdef FQ_BYPASS_EN
    bypass  = (count_q == '0) && (state_q == S_REQ) && resp_ok && deq_ready && !redirect_valid;
`else
    bypass  = 1'b0;
`endif
    enq       = (state_q == S_REQ) && resp_ok && !redirect_valid && !bypass;
    deq       = (count_q != '0) && deq_ready && !redirect_valid;
    count_nxt = CNT_W'(count_q + CNT_W'(enq) - CNT_W'(deq));
    // A new request is only issued when a slot is already reserved for its response.
    issue_ok  = fetch_en && (32'(count_nxt) < DEPTH);
  end

  // Fetch FSM and PC tracking.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    case (state_q)
      S_IDLE: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_pc;
        end else if (issue_ok) begin
          state_d  = S_REQ;
          req_pc_d = fetch_pc_q;
        end
      end
      S_REQ: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_pc;
          state_d    = resp_ok ? S_IDLE : S_DROP;
        end else if (resp_ok) begin
          fetch_pc_d = req_pc_q + 64'd4;
          if (issue_ok) begin
            req_pc_d = req_pc_q + 64'd4;
          end else begin
            state_d  = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_pc;
        end
        // The response owed to the abandoned request retires the drop.
        if (resp_ok) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Queue pointers, count and storage.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_nxt;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    if (redirect_valid) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (enq) begin
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        pc_mem_d[wr_ptr_q]    = req_pc_q;
        instr_mem_d[wr_ptr_q] = iresp.data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
    end
  end

  // Request is live in every state but IDLE; address held in req_pc until data_ok.
  always_comb begin
    ireq       = '0;
    ireq.valid = (state_q != S_IDLE);
    ireq.addr  = req_pc_q;
  end

  always_comb begin
    deq_valid = (count_q != '0) || bypass;
    deq_pc    = bypass ? req_pc_q   : pc_mem_q[rd_ptr_q];
    deq_instr = bypass ? iresp.data : instr_mem_q[rd_ptr_q];
    occupancy = count_q;
  end

endmodule
